// File: rtl/nvram_seq.sv
// NVRAM sequencer: arbitrates CPU accesses to the working SRAM against bulk
// recall (EE -> SRAM) and store (SRAM -> EE) copies, with a download path into EE.
module nvram_seq #(
    parameter logic AUTO_RECALL = 1'b1
) (
    input  logic       cl,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_ad,
    input  logic [3:0] cpu_wd,
    output logic [3:0] cpu_rd,
    output logic       cpu_ack,
    input  logic       recall,
    input  logic       store,
    input  logic       dl_en,
    input  logic [7:0] dl_ad,
    input  logic [3:0] dl_dt,
    output logic [7:0] sram_ad,
    output logic       sram_we,
    output logic [3:0] sram_wd,
    input  logic [3:0] sram_rd,
    output logic [7:0] ee_ad,
    output logic       ee_we,
    output logic [3:0] ee_wd,
    input  logic [3:0] ee_rd,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_RD   = 3'd1;
    localparam logic [2:0] CPU_DONE = 3'd2;
    localparam logic [2:0] RCL_RD   = 3'd3;
    localparam logic [2:0] RCL_WR   = 3'd4;
    localparam logic [2:0] STO_RD   = 3'd5;
    localparam logic [2:0] STO_WR   = 3'd6;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       rcl_pend;
    logic       sto_pend;
    logic       start_rcl;
    logic       start_sto;
    logic       start_cpu;
    logic       last;

    always_comb begin
        start_rcl = (state == IDLE) && rcl_pend;
        start_sto = (state == IDLE) && !rcl_pend && sto_pend;
        start_cpu = (state == IDLE) && !rcl_pend && !sto_pend && cpu_req;
        last      = (cnt == 8'hFF);
    end

    always_ff @(posedge cl or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            rcl_pend <= AUTO_RECALL;
            sto_pend <= 1'b0;
            cpu_rd   <= 4'd0;
        end else begin
            // A pulse coinciding with the start of its own copy stays pending.
            rcl_pend <= recall | (rcl_pend & ~start_rcl);
            sto_pend <= store  | (sto_pend & ~start_sto);
            case (state)
                IDLE: begin
                    if (start_rcl) begin
                        state <= RCL_RD;
                        cnt   <= 8'd0;
                    end else if (start_sto) begin
                        state <= STO_RD;
                        cnt   <= 8'd0;
                    end else if (start_cpu) begin
                        state <= cpu_rw ? CPU_DONE : CPU_RD;
                    end
                end
                CPU_RD: begin
                    cpu_rd <= sram_rd;
                    state  <= CPU_DONE;
                end
                CPU_DONE: begin
                    if (!cpu_req) state <= IDLE;
                end
                RCL_RD: begin
                    if (!dl_en) state <= RCL_WR;
                end
                RCL_WR: begin
                    cnt   <= cnt + 8'd1;
                    state <= last ? IDLE : RCL_RD;
                end
                STO_RD: begin
                    state <= STO_WR;
                end
                STO_WR: begin
                    if (!dl_en) begin
                        cnt   <= cnt + 8'd1;
                        state <= last ? IDLE : STO_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by reset_n so they drop the instant reset asserts.
    always_comb begin
        busy    = (state == RCL_RD) || (state == RCL_WR) ||
                  (state == STO_RD) || (state == STO_WR);
        cpu_ack = (state == CPU_DONE);
        sram_we = reset_n && ((start_cpu && cpu_rw) || (state == RCL_WR));
        sram_ad = ((state == RCL_WR) || (state == STO_RD) || (state == STO_WR)) ? cnt : cpu_ad;
        sram_wd = (state == RCL_WR) ? ee_rd : cpu_wd;
        ee_we   = reset_n && (dl_en || (state == STO_WR));
        ee_ad   = dl_en ? dl_ad : cnt;
        ee_wd   = dl_en ? dl_dt : sram_rd;
    end

endmodule

// File: tb/tb_nvram_seq.sv
// Bench for nvram_seq: behavioural SRAM/EE models with 1-cycle read latency,
// reference arrays for expected memory contents and a queue of expected read data.
module tb_nvram_seq;

    logic       cl = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_rw = 1'b0;
    logic [7:0] cpu_ad = 8'd0;
    logic [3:0] cpu_wd = 4'd0;
    logic       recall = 1'b0;
    logic       store = 1'b0;
    logic       dl_en = 1'b0;
    logic [7:0] dl_ad = 8'd0;
    logic [3:0] dl_dt = 4'd0;
    logic       preload = 1'b0;

    logic [3:0] cpu_rd;
    logic       cpu_ack;
    logic [7:0] sram_ad;
    logic       sram_we;
    logic [3:0] sram_wd;
    logic [3:0] sram_rd;
    logic [7:0] ee_ad;
    logic       ee_we;
    logic [3:0] ee_wd;
    logic [3:0] ee_rd;
    logic       busy;

    logic [3:0] sram_mem [256];
    logic [3:0] ee_mem   [256];
    logic [3:0] exp_sram [256];
    logic [3:0] exp_ee   [256];
    logic [3:0] rd_q [$];
    logic [7:0] dl_tab_ad [3];
    logic [3:0] dl_tab_dt [3];

    int n_checks = 0;
    int n_err = 0;

    nvram_seq dut (
        .cl      (cl),
        .reset_n (reset_n),
        .cpu_req (cpu_req),
        .cpu_rw  (cpu_rw),
        .cpu_ad  (cpu_ad),
        .cpu_wd  (cpu_wd),
        .cpu_rd  (cpu_rd),
        .cpu_ack (cpu_ack),
        .recall  (recall),
        .store   (store),
        .dl_en   (dl_en),
        .dl_ad   (dl_ad),
        .dl_dt   (dl_dt),
        .sram_ad (sram_ad),
        .sram_we (sram_we),
        .sram_wd (sram_wd),
        .sram_rd (sram_rd),
        .ee_ad   (ee_ad),
        .ee_we   (ee_we),
        .ee_wd   (ee_wd),
        .ee_rd   (ee_rd),
        .busy    (busy)
    );

    always #5 cl = ~cl;

    always @(posedge cl) begin
        if (sram_we) sram_mem[sram_ad] <= sram_wd;
        sram_rd <= sram_mem[sram_ad];
    end

    always @(posedge cl) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ee_mem[i] <= 4'(i);
        end else if (ee_we) begin
            ee_mem[ee_ad] <= ee_wd;
        end
        ee_rd <= ee_mem[ee_ad];
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sram_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) if (sram_mem[i] !== exp_sram[i]) d++;
        return d;
    endfunction

    function automatic int ee_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) if (ee_mem[i] !== exp_ee[i]) d++;
        return d;
    endfunction

    // Called on a falling edge; returns the number of cycles spent waiting for ack.
    task automatic cpu_access(input logic rw, input logic [7:0] ad, input logic [3:0] wd,
                              output int lat);
        logic [3:0] e;
        if (rw) exp_sram[ad] = wd;
        else rd_q.push_back(exp_sram[ad]);
        cpu_req = 1'b1;
        cpu_rw  = rw;
        cpu_ad  = ad;
        cpu_wd  = wd;
        lat = 0;
        while (!cpu_ack && lat < 3000) begin
            @(negedge cl);
            lat++;
        end
        if (!cpu_ack) begin
            check("cpu_ack_timeout", 0, 1);
            lat = -1;
            if (!rw) void'(rd_q.pop_front());
        end else if (!rw) begin
            e = rd_q.pop_front();
            check("cpu_rd_data", int'(cpu_rd), int'(e));
        end
        cpu_req = 1'b0;
        @(negedge cl);
        check("cpu_ack_drop", int'(cpu_ack), 0);
    endtask

    // Waits (bounded) for a copy to begin and counts its busy cycles; -1 if none started.
    task automatic wait_copy(output int cyc);
        int g;
        cyc = 0;
        g = 0;
        while (!busy && g < 100) begin
            @(negedge cl);
            g++;
        end
        if (!busy) begin
            cyc = -1;
            return;
        end
        while (busy && cyc < 3000) begin
            cyc++;
            @(negedge cl);
        end
    endtask

    initial begin
        int lat, cyc, g, idx, cnt, after, nbusy, rises, low_run;
        logic prev;
        logic [3:0] e;
        logic [3:0] old_ee [256];

        dl_tab_ad[0] = 8'h05; dl_tab_dt[0] = 4'h9;
        dl_tab_ad[1] = 8'h06; dl_tab_dt[1] = 4'h3;
        dl_tab_ad[2] = 8'hF0; dl_tab_dt[2] = 4'hE;
        for (int i = 0; i < 256; i++) exp_ee[i] = 4'(i);

        // Reset state, then auto-recall of the preloaded EE image
        preload = 1'b1;
        @(negedge cl);
        preload = 1'b0;
        @(negedge cl);
        check("rst_busy", int'(busy), 0);
        check("rst_cpu_ack", int'(cpu_ack), 0);
        check("rst_cpu_rd", int'(cpu_rd), 0);
        check("rst_sram_we", int'(sram_we), 0);
        check("rst_ee_we", int'(ee_we), 0);
        reset_n = 1'b1;
        wait_copy(cyc);
        check("t1_busy_cycles", cyc, 512);
        for (int i = 0; i < 256; i++) exp_sram[i] = exp_ee[i];
        check("t1_sram_bad_entries", sram_diff(), 0);

        // CPU write / read latencies
        cpu_access(1'b1, 8'h10, 4'h5, lat);
        check("t2_wr_ack_lat", lat, 1);
        cpu_access(1'b0, 8'h10, 4'h0, lat);
        check("t2_rd_ack_lat", lat, 2);
        cpu_access(1'b1, 8'h00, 4'hF, lat);
        cpu_access(1'b1, 8'h33, 4'h7, lat);
        cpu_access(1'b1, 8'hFF, 4'h9, lat);
        cpu_access(1'b0, 8'hFF, 4'h0, lat);

        // Store with a CPU read stalled from copy cycle 10
        store = 1'b1;
        @(negedge cl);
        store = 1'b0;
        g = 0;
        while (!busy && g < 10) begin
            @(negedge cl);
            g++;
        end
        check("t3_busy_start", int'(busy), 1);
        nbusy = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) nbusy++;
            @(negedge cl);
        end
        rd_q.push_back(exp_sram[8'h33]);
        cpu_req = 1'b1;
        cpu_rw  = 1'b0;
        cpu_ad  = 8'h33;
        after = 0;
        g = 0;
        while (!cpu_ack && g < 3000) begin
            if (busy) nbusy++;
            else after++;
            @(negedge cl);
            g++;
        end
        check("t3_busy_cycles", nbusy, 512);
        check("t3_busy_at_ack", int'(busy), 0);
        check("t3_ack_after_busy", after, 2);
        e = rd_q.pop_front();
        check("t3_cpu_rd", int'(cpu_rd), int'(e));
        cpu_req = 1'b0;
        @(negedge cl);
        for (int i = 0; i < 256; i++) exp_ee[i] = exp_sram[i];
        check("t3_ee_bad_entries", ee_diff(), 0);

        // Simultaneous recall and store: recall must run first
        cpu_access(1'b1, 8'h20, 4'hA, lat);
        recall = 1'b1;
        store  = 1'b1;
        @(negedge cl);
        recall = 1'b0;
        store  = 1'b0;
        nbusy = 0; rises = 0; prev = 1'b0; low_run = 0; g = 0;
        while (low_run < 4 && g < 3000) begin
            if (busy) begin
                nbusy++;
                low_run = 0;
                if (!prev) rises++;
            end else if (nbusy > 0) begin
                low_run++;
            end
            prev = busy;
            @(negedge cl);
            g++;
        end
        check("t4_busy_cycles", nbusy, 1024);
        check("t4_copy_count", rises, 2);
        for (int i = 0; i < 256; i++) exp_sram[i] = exp_ee[i];
        check("t4_sram_bad_entries", sram_diff(), 0);
        check("t4_ee_bad_entries", ee_diff(), 0);

        // Download for 3 cycles starting at a recall read cycle (copy address 10)
        cpu_access(1'b1, 8'h50, 4'hC, lat);
        recall = 1'b1;
        @(negedge cl);
        recall = 1'b0;
        g = 0;
        while (!busy && g < 10) begin
            @(negedge cl);
            g++;
        end
        check("t5_busy_start", int'(busy), 1);
        for (int i = 0; i < 256; i++) old_ee[i] = exp_ee[i];
        idx = 0;
        cnt = 0;
        while (busy && idx < 3000) begin
            cnt++;
            if (idx >= 20 && idx < 23) begin
                dl_en = 1'b1;
                dl_ad = dl_tab_ad[idx-20];
                dl_dt = dl_tab_dt[idx-20];
            end else begin
                dl_en = 1'b0;
            end
            idx++;
            @(negedge cl);
        end
        dl_en = 1'b0;
        check("t5_busy_cycles", cnt, 515);
        for (int k = 0; k < 3; k++) exp_ee[dl_tab_ad[k]] = dl_tab_dt[k];
        for (int i = 0; i < 256; i++) exp_sram[i] = (i < 10) ? old_ee[i] : exp_ee[i];
        check("t5_ee_bad_entries", ee_diff(), 0);
        check("t5_sram_bad_entries", sram_diff(), 0);

        // Reset at copy address 0x80, with a store made pending mid-copy
        for (int i = 128; i < 256; i++) begin
            dl_en = 1'b1;
            dl_ad = 8'(i);
            dl_dt = 4'(i) ^ 4'hF;
            exp_ee[i] = 4'(i) ^ 4'hF;
            @(negedge cl);
        end
        dl_en = 1'b0;
        check("t6_download_ee", ee_diff(), 0);
        recall = 1'b1;
        @(negedge cl);
        recall = 1'b0;
        g = 0;
        while (!busy && g < 10) begin
            @(negedge cl);
            g++;
        end
        idx = 0;
        while (busy && idx < 256) begin
            store = (idx == 100);
            idx++;
            @(negedge cl);
        end
        store = 1'b0;
        check("t6_busy_at_0x80", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_sram_we", int'(sram_we), 0);
        check("t6_rst_ee_we", int'(ee_we), 0);
        for (int i = 0; i < 128; i++) exp_sram[i] = exp_ee[i];
        repeat (3) @(negedge cl);
        check("t6_sram_after_abort", sram_diff(), 0);
        reset_n = 1'b1;
        wait_copy(cyc);
        check("t6_auto_recall_cycles", cyc, 512);
        nbusy = 0;
        repeat (600) begin
            @(negedge cl);
            if (busy) nbusy++;
        end
        check("t6_no_store_after_reset", nbusy, 0);
        for (int i = 0; i < 256; i++) exp_sram[i] = exp_ee[i];
        check("t6_sram_bad_entries", sram_diff(), 0);
        check("t6_ee_bad_entries", ee_diff(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
